// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with an 8-bit register file, oversampled on clk; single and burst read/write frames.
// Optional error counter port err_cnt is enabled by defining SPI_SLAVE_REGS_ERRCNT_EN.
module spi_slave_regs #(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_b,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic                  frame_done
`ifdef SPI_SLAVE_REGS_ERRCNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t       state, state_next;
    logic [2:0]   cs_pipe, sclk_pipe;
    logic [1:0]   mosi_pipe;
    logic         cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
    logic [7:0]   reg_file [NUM_REGS];
    logic [2:0]   bit_cnt, bit_cnt_next;
    logic [6:0]   shift_in;
    logic [7:0]   rx_byte, tx;
    logic         rw, byte_seen;
    logic [6:0]   addr;
    logic         active, byte_done;

    function automatic logic in_range(input logic [6:0] a);
        return {1'b0, a} < NUM_REGS_B;
    endfunction

    function automatic logic [7:0] read_reg(input logic [6:0] a);
        return in_range(a) ? reg_file[a[AW-1:0]] : 8'h00;
    endfunction

    // cs_b synchronizer resets low so a frame can only start after cs_b has been seen high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_pipe   <= 3'b000;
            sclk_pipe <= 3'b000;
            mosi_pipe <= 2'b00;
        end else begin
            cs_pipe   <= {cs_pipe[1:0], cs_b};
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            mosi_pipe <= {mosi_pipe[0], mosi};
        end
    end

    assign cs_rise      = cs_pipe[1] & ~cs_pipe[2];
    assign cs_fall      = ~cs_pipe[1] & cs_pipe[2];
    assign sclk_rise    = sclk_pipe[1] & ~sclk_pipe[2];
    assign sclk_fall    = ~sclk_pipe[1] & sclk_pipe[2];
    assign mosi_s       = mosi_pipe[1];
    assign active       = (state != IDLE);
    assign byte_done    = active & sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte      = {shift_in, mosi_s};
    assign bit_cnt_next = (active & sclk_rise) ? bit_cnt + 3'd1 : bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: next state is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = CMD;
            CMD:     if (cs_rise) state_next = IDLE;
                     else if (byte_done) state_next = DATA;
            DATA:    if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the register file is reset explicitly; its contents are architecturally visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            shift_in   <= 7'd0;
            tx         <= 8'h00;
            rw         <= 1'b0;
            addr       <= 7'd0;
            byte_seen  <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 7'd0;
            wr_data    <= 8'h00;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= RESET_VAL;
        end else begin
            wr_strobe  <= 1'b0;
            frame_done <= 1'b0;
            if (state == IDLE && cs_fall) begin
                bit_cnt   <= 3'd0;
                byte_seen <= 1'b0;
                tx        <= 8'h00;
                rw        <= 1'b0;
            end
            if (active && sclk_rise) begin
                shift_in <= rx_byte[6:0];
                bit_cnt  <= bit_cnt_next;
                if (byte_done) begin
                    byte_seen <= 1'b1;
                    if (state == CMD) begin
                        rw   <= rx_byte[7];
                        addr <= rx_byte[6:0];
                        tx   <= rx_byte[7] ? read_reg(rx_byte[6:0]) : 8'h00;
                    end else begin
                        addr <= addr + 7'd1;
                        if (rw) begin
                            tx <= read_reg(addr + 7'd1);
                        end else if (in_range(addr)) begin
                            reg_file[addr[AW-1:0]] <= rx_byte;
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= rx_byte;
                        end
                    end
                end
            end else if (state == DATA && rw && sclk_fall && bit_cnt != 3'd0) begin
                // The fall right after a byte boundary keeps bit 7 for the master's next rise.
                tx <= {tx[6:0], 1'b0};
            end
            if (active && cs_rise) frame_done <= byte_seen | byte_done;
        end
    end

    assign miso = (state == DATA) & rw & tx[7];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign regs[8*i +: 8] = reg_file[i];
    end

`ifdef SPI_SLAVE_REGS_ERRCNT_EN
    logic partial, wr_miss;

    assign partial = active & cs_rise & (bit_cnt_next != 3'd0);
    assign wr_miss = byte_done & (state == DATA) & ~rw & ~in_range(addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       err_cnt <= 8'h00;
        else if ((partial | wr_miss) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
`endif

endmodule
